bnn_seq_classifier: RTL and testbench
=====================================

BNN_SEQ_CLASSIFIER -- requirements
Module: bnn_seq_classifier

Interface
REQ-001 SHALL have parameter FEAT_CNT, default 11, number of input features.
REQ-002 SHALL have parameter HIDDEN_CNT, default 40, number of hidden binary neurons.
REQ-003 SHALL have parameter FEAT_BITS, default 4, width of each unsigned feature.
REQ-004 SHALL have parameter CLASS_CNT, default 6, number of output classes.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset; rst release also starts a classification.
REQ-007 SHALL have port features, input, FEAT_BITS*FEAT_CNT, packed features, feature 0 in the LSBs.
REQ-008 SHALL have port prediction, output, $clog2(CLASS_CNT), winning class index.
REQ-009 SHALL have port done, output, 1, high while prediction is valid.

Function
REQ-010 SHALL register features into an internal latch on every clk edge where rst=1; features are ignored while rst=0.
REQ-011 SHALL binarize each latched feature as its MSB (1 = value >= 2^(FEAT_BITS-1)).
REQ-012 SHALL implement states RST, HID, CLS, DONE: RST->HID on the first edge with rst=0; HID->CLS after HIDDEN_CNT cycles; CLS->DONE after CLASS_CNT cycles; DONE holds until rst.
REQ-013 SHALL in HID evaluate one hidden neuron j per cycle, j=0..HIDDEN_CNT-1: h[j] = (popcount(XNOR(xbin, W1[j])) >= T1[j]), stored into an HIDDEN_CNT-bit register.
REQ-014 SHALL use $clog2(FEAT_CNT+1) bits for hidden sums and $clog2(HIDDEN_CNT+1) bits for class scores, with no truncation.
REQ-015 SHALL in CLS compute one class score per cycle, c=0..CLASS_CNT-1: s[c] = popcount(XNOR(h, W2[c])), using the fully written h.
REQ-016 SHALL keep a running best (score, index) and replace it only on strictly greater score, so ties resolve to the lowest class index.
REQ-017 SHALL load prediction with the best index and set done=1 on the edge entering DONE: exactly HIDDEN_CNT+CLASS_CNT edges after the first rst=0 edge.
REQ-018 SHALL hold prediction and done constant in DONE; prediction SHALL NOT change outside the DONE-entry edge.
REQ-019 SHALL treat W1, T1, W2 as read-only constants indexed by the neuron/class counter; no write path.

Reset
REQ-020 SHALL, on any edge with rst=1 (including mid-HID/CLS), force state RST, counters 0, h 0, best score 0, best index 0, prediction 0, done 0.
REQ-021 SHALL restart with full latency after a mid-operation reset; partial results SHALL NOT leak.

Structure
REQ-022 SHALL place FEAT_CNT/HIDDEN_CNT/FEAT_BITS/CLASS_CNT defaults, derived widths, state enum, and W1/T1/W2 constant arrays in a shared package bnn_seq_pkg; dataset-specific weight sets SHALL be generated package variants.
REQ-023 SHALL use one sub-module, bnn_popcount (parameterized width, combinational), instantiated for hidden and class sums.

Verification
REQ-024 Reset: rst=1 for 3 cycles with arbitrary features -> prediction=0, done=0 every cycle.
REQ-025 Latency: defaults, rst released at edge E -> done rises at edge E+46, not E+45; stays 1 for 20 further cycles with prediction stable.
REQ-026 Known vector: test weights W1 all-ones, T1=11, W2[4] all-ones, others all-zeros; features all 0xF -> prediction=4; features all 0x0 -> h=0, classes 0,1,2,3,5 score 40 -> prediction=0.
REQ-027 Tie: all W2 rows identical -> prediction=0 for any features.
REQ-028 Mid-op reset: rst asserted 1 cycle at E+20 -> done=0, prediction=0 immediately; done rises 46 edges after the new release with correct class; features changed at E+10 have no effect.
REQ-029 Regression: 1000 vectors from winered.memh, one per reset cycle -> predictions match the software BNN model bit-exactly.

Source files
------------

// File: rtl/bnn_seq_pkg.sv
// Shared defaults, derived widths, FSM state type and the weight set
// for the sequential binary classifier (test weight variant).
package bnn_seq_pkg;

    localparam int FEAT_CNT_DEF   = 11;
    localparam int HIDDEN_CNT_DEF = 40;
    localparam int FEAT_BITS_DEF  = 4;
    localparam int CLASS_CNT_DEF  = 6;

    localparam int SUM_W_DEF   = $clog2(FEAT_CNT_DEF + 1);
    localparam int SCORE_W_DEF = $clog2(HIDDEN_CNT_DEF + 1);
    localparam int PRED_W_DEF  = $clog2(CLASS_CNT_DEF);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_HID  = 2'd1,
        ST_CLS  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Row j of W1 / entry j of T1 / row c of W2 sit at the matching slice offset.
    localparam logic [HIDDEN_CNT_DEF*FEAT_CNT_DEF-1:0] W1_DEF =
        {(HIDDEN_CNT_DEF*FEAT_CNT_DEF){1'b1}};
    localparam logic [HIDDEN_CNT_DEF*SUM_W_DEF-1:0] T1_DEF =
        {HIDDEN_CNT_DEF{SUM_W_DEF'(11)}};
    localparam logic [CLASS_CNT_DEF*HIDDEN_CNT_DEF-1:0] W2_DEF =
        {{HIDDEN_CNT_DEF{1'b0}}, {HIDDEN_CNT_DEF{1'b1}}, {(4*HIDDEN_CNT_DEF){1'b0}}};

endpackage

// File: rtl/bnn_popcount.sv
// Combinational population count over a parameterised bit vector.
module bnn_popcount #(
    parameter int WIDTH = 8,
    parameter int OUT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] bits,
    output logic [OUT_W-1:0] count
);

    // Ripple accumulation of set bits
    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + OUT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/bnn_seq_classifier.sv
// Sequential binarised neural network: one hidden neuron per cycle, then one
// class score per cycle, argmax with ties resolved to the lowest class.
module bnn_seq_classifier
    import bnn_seq_pkg::*;
#(
    parameter int FEAT_CNT   = FEAT_CNT_DEF,
    parameter int HIDDEN_CNT = HIDDEN_CNT_DEF,
    parameter int FEAT_BITS  = FEAT_BITS_DEF,
    parameter int CLASS_CNT  = CLASS_CNT_DEF,
    parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]               W1 = W1_DEF,
    parameter logic [HIDDEN_CNT*$clog2(FEAT_CNT+1)-1:0]     T1 = T1_DEF,
    parameter logic [CLASS_CNT*HIDDEN_CNT-1:0]              W2 = W2_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [FEAT_BITS*FEAT_CNT-1:0] features,
    output logic [$clog2(CLASS_CNT)-1:0]  prediction,
    output logic                          done
);

    localparam int SUM_W   = $clog2(FEAT_CNT + 1);
    localparam int SCORE_W = $clog2(HIDDEN_CNT + 1);
    localparam int PRED_W  = $clog2(CLASS_CNT);
    localparam int CNT_MAX = (HIDDEN_CNT > CLASS_CNT) ? HIDDEN_CNT : CLASS_CNT;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] HID_LAST = CNT_W'(HIDDEN_CNT - 1);
    localparam logic [CNT_W-1:0] CLS_LAST = CNT_W'(CLASS_CNT - 1);

    state_t                        state_r, state_nxt_s;
    logic [CNT_W-1:0]              cnt_r;
    logic [FEAT_BITS*FEAT_CNT-1:0] feat_r;
    logic [HIDDEN_CNT-1:0]         h_r;
    logic [SCORE_W-1:0]            best_score_r;
    logic [PRED_W-1:0]             best_idx_r;
    logic [FEAT_CNT-1:0]           xbin_s, w1_row_s, hid_xnor_s;
    logic [SUM_W-1:0]              t1_s, hid_sum_s;
    logic [HIDDEN_CNT-1:0]         w2_row_s, cls_xnor_s;
    logic [SCORE_W-1:0]            cls_score_s;
    logic                          hid_en_s, cls_en_s, done_entry_s, hid_bit_s, better_s;
    logic [PRED_W-1:0]             cand_idx_s;

    // Binarise each latched feature by its MSB
    always_comb begin
        xbin_s = '0;
        for (int i = 0; i < FEAT_CNT; i++) begin
            xbin_s[i] = feat_r[i*FEAT_BITS + FEAT_BITS - 1];
        end
    end

    // Weight rows are only addressed while their phase is active
    always_comb begin
        w1_row_s = '0;
        t1_s     = '0;
        w2_row_s = '0;
        if (hid_en_s) begin
            w1_row_s = W1[int'(cnt_r)*FEAT_CNT +: FEAT_CNT];
            t1_s     = T1[int'(cnt_r)*SUM_W +: SUM_W];
        end else begin
            w1_row_s = '0;
            t1_s     = '0;
        end
        if (cls_en_s) begin
            w2_row_s = W2[int'(cnt_r)*HIDDEN_CNT +: HIDDEN_CNT];
        end else begin
            w2_row_s = '0;
        end
    end

    assign hid_xnor_s = ~(xbin_s ^ w1_row_s);
    assign cls_xnor_s = ~(h_r ^ w2_row_s);

    bnn_popcount #(.WIDTH(FEAT_CNT), .OUT_W(SUM_W)) u_hid_pop (
        .bits  (hid_xnor_s),
        .count (hid_sum_s)
    );

    bnn_popcount #(.WIDTH(HIDDEN_CNT), .OUT_W(SCORE_W)) u_cls_pop (
        .bits  (cls_xnor_s),
        .count (cls_score_s)
    );

    // Neuron activation and strict-greater argmax candidate
    always_comb begin
        hid_bit_s = (hid_sum_s >= t1_s);
        better_s  = (cls_score_s > best_score_r);
        if (better_s) begin
            cand_idx_s = cnt_r[PRED_W-1:0];
        end else begin
            cand_idx_s = best_idx_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RST;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RST:  state_nxt_s = ST_HID;
            ST_HID:  state_nxt_s = (cnt_r == HID_LAST) ? ST_CLS : ST_HID;
            ST_CLS:  state_nxt_s = (cnt_r == CLS_LAST) ? ST_DONE : ST_CLS;
            ST_DONE: state_nxt_s = ST_DONE;
            default: state_nxt_s = ST_RST;
        endcase
    end

    // FSM output decode
    always_comb begin
        hid_en_s     = (state_r == ST_HID);
        cls_en_s     = (state_r == ST_CLS);
        done_entry_s = (state_r == ST_CLS) && (cnt_r == CLS_LAST);
    end

    // Datapath registers: feature latch, counter, hidden vector, argmax, outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            feat_r       <= features;
            cnt_r        <= '0;
            h_r          <= '0;
            best_score_r <= '0;
            best_idx_r   <= '0;
            prediction   <= '0;
            done         <= 1'b0;
        end else begin
            if (state_r != state_nxt_s) begin
                cnt_r <= '0;
            end else if (hid_en_s || cls_en_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (hid_en_s) begin
                h_r[cnt_r] <= hid_bit_s;
            end
            if (cls_en_s && better_s) begin
                best_score_r <= cls_score_s;
                best_idx_r   <= cnt_r[PRED_W-1:0];
            end
            if (done_entry_s) begin
                prediction <= cand_idx_s;
                done       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bnn_seq_classifier.sv
// Directed bench: default-weight instance plus a tie instance whose W2 rows
// are all identical, driven from one shared stimulus.
module tb_bnn_seq_classifier;

    localparam logic [239:0] TIE_W2 = {6{40'hA5A5A5A5A5}};

    logic        clk;
    logic        rst;
    logic [43:0] features;
    logic [2:0]  prediction, tie_prediction;
    logic        done, tie_done;

    int total_checks = 0;
    int pass_checks  = 0;

    typedef struct {
        string       name;
        logic [43:0] feat;
        logic [2:0]  exp_pred;
    } vec_t;

    vec_t vecs [8];

    bnn_seq_classifier dut (
        .clk        (clk),
        .rst        (rst),
        .features   (features),
        .prediction (prediction),
        .done       (done)
    );

    bnn_seq_classifier #(.W2(TIE_W2)) dut_tie (
        .clk        (clk),
        .rst        (rst),
        .features   (features),
        .prediction (tie_prediction),
        .done       (tie_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            pass_checks++;
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " prediction"}, 64'(prediction), 64'd0);
        check({tag, " tie done"}, 64'(tie_done), 64'd0);
        check({tag, " tie prediction"}, 64'(tie_prediction), 64'd0);
    endtask

    // Wait for done (bounded), then check latency counted from the release edge E.
    task automatic wait_result(input string tag, input logic [2:0] exp_pred);
        int lat;
        bit got;
        lat = -1;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(posedge clk); #1;
            lat++;
            if (done) got = 1'b1;
        end
        check({tag, " latency"}, 64'(lat), 64'd46);
        check({tag, " prediction"}, 64'(prediction), 64'(exp_pred));
        check({tag, " tie done"}, 64'(tie_done), 64'd1);
        check({tag, " tie prediction"}, 64'(tie_prediction), 64'd0);
    endtask

    task automatic classify(input string tag, input logic [43:0] f, input logic [2:0] exp_pred);
        @(posedge clk); #1;
        rst = 1'b1;
        features = f;
        @(posedge clk); #1;
        check_cleared({tag, " after reset"});
        rst = 1'b0;
        features = ~f;
        wait_result(tag, exp_pred);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{"all_F",       44'hFFFFFFFFFFF, 3'd4};
        vecs[1] = '{"all_0",       44'h00000000000, 3'd0};
        vecs[2] = '{"all_8",       44'h88888888888, 3'd4};
        vecs[3] = '{"all_7",       44'h77777777777, 3'd0};
        vecs[4] = '{"f0_is_7",     44'hFFFFFFFFFF7, 3'd0};
        vecs[5] = '{"f10_is_0",    44'h0FFFFFFFFFF, 3'd0};
        vecs[6] = '{"mixed_hi",    44'h89ABCDEF8F9, 3'd4};
        vecs[7] = '{"mixed_one7",  44'h89ABCDEF879, 3'd0};

        rst = 1'b1;
        features = 44'h123456789AB;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_cleared($sformatf("reset cycle %0d", c));
            features = features ^ 44'h5A5A5A5A5A5;
        end

        for (int v = 0; v < 8; v++) begin
            classify(vecs[v].name, vecs[v].feat, vecs[v].exp_pred);
        end

        // Result holds for 20 cycles after done rises
        classify("hold_run", 44'hFFFFFFFFFFF, 3'd4);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold done %0d", c), 64'(done), 64'd1);
            check($sformatf("hold prediction %0d", c), 64'(prediction), 64'd4);
        end

        // Mid-operation reset: input change at E+10 ignored, reset at E+20 restarts
        @(posedge clk); #1;
        rst = 1'b1;
        features = 44'hFFFFFFFFFFF;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        features = 44'h00000000000;
        repeat (9) @(posedge clk);
        #1;
        check("midop done before reset", 64'(done), 64'd0);
        rst = 1'b1;
        features = 44'h88888888888;
        @(posedge clk); #1;
        check_cleared("midop reset");
        rst = 1'b0;
        features = 44'h00000000000;
        wait_result("midop rerun", 3'd4);

        // A fresh run with all-zero inputs must not inherit the previous answer
        classify("after_midop", 44'h00000000000, 3'd0);

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
